// File: rtl/bp_mig_app_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_mig_app_pkg
// Description : Shared types for the cache-DMA to MIG app-interface adapter.
//               MIG native command encodings and the adapter FSM states.
//               The DMA packet struct depends on the address-width parameter,
//               so it is declared inside the adapter itself.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_mig_app_pkg;

    // MIG 7-series native app_cmd encodings
    typedef enum logic [2:0] {
        e_mig_app_cmd_write = 3'b000,
        e_mig_app_cmd_read  = 3'b001
    } bp_mig_app_cmd_e;

    // Adapter control FSM
    typedef enum logic [2:0] {
        e_idle       = 3'd0,
        e_rd_cmd     = 3'd1,
        e_wr_collect = 3'd2,
        e_wr_data    = 3'd3,
        e_wr_cmd     = 3'd4
    } bp_mig_app_state_e;

endpackage : bp_mig_app_pkg
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fifo_1r1w_small
// Description : Small circular FIFO, one write port and one read port,
//               valid/ready on input, valid/yumi on output. Data storage is
//               not reset; only pointers and occupancy are.
// Ports       : clk_i, reset_i (async, active-high)
//               v_i/ready_o/data_i   - push side
//               v_o/data_o/yumi_i    - pop side (data_o is the head entry)
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int width_p = 128,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int c_PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int c_CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] r_mem [els_p];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign ready_o = (r_count != c_CNT_W'(els_p));
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PTR_W'(els_p - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_W'(els_p - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bsg_fifo_1r1w_small
`default_nettype wire

// File: rtl/mig_dma_app_adapter.sv
`default_nettype none
// ============================================================================
// Module      : mig_dma_app_adapter
// Description : Bridges the bsg_cache DMA port to the Xilinx MIG 7-series
//               native app interface, all in the MIG ui_clk domain. One
//               block-sized packet at a time, split into BL8 bursts; write
//               beats are packed into app words, read returns are buffered
//               and unpacked back into DMA beats.
// Ports       : clk_i, reset_i (async, active-high)
//               dma_pkt_*   - packet {write_not_read, addr} from the cache
//               dma_data_o* - read beats to the cache (valid/ready)
//               dma_data_i* - write beats from the cache (valid/yumi)
//               app_*       - MIG native command, write-data and read-data
//               init_calib_complete_i - gates packet acceptance only
// Revision    : 1.0 - initial release
// ============================================================================
module mig_dma_app_adapter
    import bp_mig_app_pkg::*;
#(
    parameter int caddr_width_p    = 28,
    parameter int dma_data_width_p = 64,
    parameter int block_width_p    = 512,
    parameter int app_data_width_p = 128,
    parameter int app_addr_width_p = 28,
    parameter int dram_width_p     = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          init_calib_complete_i,

    input  logic [caddr_width_p:0]        dma_pkt_i,
    input  logic                          dma_pkt_v_i,
    output logic                          dma_pkt_yumi_o,

    output logic [dma_data_width_p-1:0]   dma_data_o,
    output logic                          dma_data_v_o,
    input  logic                          dma_data_ready_and_i,

    input  logic [dma_data_width_p-1:0]   dma_data_i,
    input  logic                          dma_data_v_i,
    output logic                          dma_data_yumi_o,

    output logic [app_addr_width_p-1:0]   app_addr_o,
    output logic [2:0]                    app_cmd_o,
    output logic                          app_en_o,
    input  logic                          app_rdy_i,

    output logic [app_data_width_p-1:0]   app_wdf_data_o,
    output logic [app_data_width_p/8-1:0] app_wdf_mask_o,
    output logic                          app_wdf_wren_o,
    output logic                          app_wdf_end_o,
    input  logic                          app_wdf_rdy_i,

    input  logic [app_data_width_p-1:0]   app_rd_data_i,
    input  logic                          app_rd_data_valid_i
);

    localparam int c_R      = app_data_width_p / dma_data_width_p;
    localparam int c_B      = block_width_p / app_data_width_p;
    localparam int c_K_W    = (c_B > 1) ? $clog2(c_B) : 1;
    localparam int c_BEAT_W = (c_R > 1) ? $clog2(c_R) : 1;
    localparam int c_PEND_W = $clog2(c_B + 1);
    localparam int c_BYTES_PER_COL = dram_width_p / 8;
    localparam logic [app_addr_width_p-1:0] c_COL_STEP =
        app_addr_width_p'(app_data_width_p / dram_width_p);

    typedef struct packed {
        logic                     write_not_read;
        logic [caddr_width_p-1:0] addr;
    } bsg_cache_dma_pkt_s;

    bsg_cache_dma_pkt_s          w_pkt;
    logic [caddr_width_p-1:0]    w_pkt_col;

    bp_mig_app_state_e           r_state;
    bp_mig_app_state_e           w_state_next;
    logic [c_K_W-1:0]            r_k;
    logic [app_addr_width_p-1:0] r_base;
    logic [c_BEAT_W-1:0]         r_beat;
    logic [app_data_width_p-1:0] r_wdata;
    logic [c_BEAT_W-1:0]         r_rd_sel;
    logic [c_PEND_W-1:0]         r_rd_pending;

    logic                        w_last_burst;
    logic                        w_last_beat;
    logic                        w_rd_cmd_accept;
    logic                        w_fifo_ready;
    logic                        w_fifo_v;
    logic [app_data_width_p-1:0] w_fifo_data;
    logic                        w_beat_take;
    logic                        w_pop;
    logic                        w_rd_idle;

    assign w_pkt     = dma_pkt_i;
    assign w_pkt_col = w_pkt.addr / caddr_width_p'(c_BYTES_PER_COL);

    assign w_last_burst    = (r_k == c_K_W'(c_B - 1));
    assign w_last_beat     = (r_beat == c_BEAT_W'(c_R - 1));
    assign w_rd_cmd_accept = (r_state == e_rd_cmd) & app_rdy_i;

    // A read is only accepted when no earlier read is still owed to the
    // cache: not merely an empty buffer, but also no returns still in
    // flight inside the MIG. This keeps the B-entry buffer from overflowing
    // even when the MIG read latency exceeds the command phase.
    assign w_rd_idle = (r_rd_pending == '0) & w_fifo_ready;

    assign app_addr_o     = r_base + app_addr_width_p'(r_k) * c_COL_STEP;
    assign app_wdf_data_o = r_wdata;
    assign app_wdf_mask_o = '0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        app_en_o        = 1'b0;
        app_cmd_o       = e_mig_app_cmd_write;
        app_wdf_wren_o  = 1'b0;
        app_wdf_end_o   = 1'b0;
        case (r_state)
            e_idle: begin
                dma_pkt_yumi_o = dma_pkt_v_i & init_calib_complete_i
                               & (w_pkt.write_not_read | w_rd_idle);
                if (dma_pkt_yumi_o) begin
                    w_state_next = w_pkt.write_not_read ? e_wr_collect : e_rd_cmd;
                end
            end
            e_rd_cmd: begin
                app_en_o  = 1'b1;
                app_cmd_o = e_mig_app_cmd_read;
                if (app_rdy_i && w_last_burst) begin
                    w_state_next = e_idle;
                end
            end
            e_wr_collect: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i && w_last_beat) begin
                    w_state_next = e_wr_data;
                end
            end
            e_wr_data: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_end_o  = 1'b1;
                if (app_wdf_rdy_i) begin
                    w_state_next = e_wr_cmd;
                end
            end
            e_wr_cmd: begin
                app_en_o  = 1'b1;
                app_cmd_o = e_mig_app_cmd_write;
                if (app_rdy_i) begin
                    w_state_next = w_last_burst ? e_idle : e_wr_collect;
                end
            end
            default: begin
                w_state_next = e_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst / beat bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_k          <= '0;
            r_base       <= '0;
            r_beat       <= '0;
            r_rd_sel     <= '0;
            r_rd_pending <= '0;
        end else begin
            if (dma_pkt_yumi_o) begin
                r_base <= app_addr_width_p'(w_pkt_col);
                r_k    <= '0;
                r_beat <= '0;
            end else if (app_en_o && app_rdy_i) begin
                r_k <= r_k + 1'b1;
            end

            if (dma_data_yumi_o) begin
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end

            if (w_beat_take) begin
                r_rd_sel <= (r_rd_sel == c_BEAT_W'(c_R - 1)) ? '0 : r_rd_sel + 1'b1;
            end

            case ({w_rd_cmd_accept, w_pop})
                2'b10:   r_rd_pending <= r_rd_pending + 1'b1;
                2'b01:   r_rd_pending <= r_rd_pending - 1'b1;
                default: r_rd_pending <= r_rd_pending;
            endcase
        end
    end

    // Write word register: beat j lands in slice j, beat 0 in the LSBs.
    always_ff @(posedge clk_i) begin
        if (dma_data_yumi_o) begin
            r_wdata[r_beat*dma_data_width_p +: dma_data_width_p] <= dma_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Read return path: MIG data cannot be stalled, so it is pushed
    // unconditionally and unpacked one slice per cache handshake.
    // ------------------------------------------------------------------
    bsg_fifo_1r1w_small #(
        .width_p (app_data_width_p),
        .els_p   (c_B)
    ) u_rd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (app_rd_data_valid_i),
        .ready_o (w_fifo_ready),
        .data_i  (app_rd_data_i),
        .v_o     (w_fifo_v),
        .data_o  (w_fifo_data),
        .yumi_i  (w_pop)
    );

    assign w_beat_take  = w_fifo_v & dma_data_ready_and_i;
    assign w_pop        = w_beat_take & (r_rd_sel == c_BEAT_W'(c_R - 1));
    assign dma_data_v_o = w_fifo_v;
    assign dma_data_o   = w_fifo_data[r_rd_sel*dma_data_width_p +: dma_data_width_p];

endmodule : mig_dma_app_adapter
`default_nettype wire

// File: tb/tb_mig_dma_app_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_dma_app_adapter
// Description : Directed self-checking bench for mig_dma_app_adapter with a
//               hand-driven MIG model. Inputs change 1 time unit after the
//               rising edge; outputs are checked 3 units after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_dma_app_adapter;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         init_calib_complete_i;
    logic [28:0]  dma_pkt_i;
    logic         dma_pkt_v_i;
    logic         dma_pkt_yumi_o;
    logic [63:0]  dma_data_o;
    logic         dma_data_v_o;
    logic         dma_data_ready_and_i;
    logic [63:0]  dma_data_i;
    logic         dma_data_v_i;
    logic         dma_data_yumi_o;
    logic [27:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o;
    logic         app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o;
    logic         app_wdf_end_o;
    logic         app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [127:0] rd_word [8];
    logic [63:0]  wr_beat [8];
    logic [63:0]  exp_q [$];

    always #5 clk_i = ~clk_i;

    mig_dma_app_adapter dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .init_calib_complete_i (init_calib_complete_i),
        .dma_pkt_i             (dma_pkt_i),
        .dma_pkt_v_i           (dma_pkt_v_i),
        .dma_pkt_yumi_o        (dma_pkt_yumi_o),
        .dma_data_o            (dma_data_o),
        .dma_data_v_o          (dma_data_v_o),
        .dma_data_ready_and_i  (dma_data_ready_and_i),
        .dma_data_i            (dma_data_i),
        .dma_data_v_i          (dma_data_v_i),
        .dma_data_yumi_o       (dma_data_yumi_o),
        .app_addr_o            (app_addr_o),
        .app_cmd_o             (app_cmd_o),
        .app_en_o              (app_en_o),
        .app_rdy_i             (app_rdy_i),
        .app_wdf_data_o        (app_wdf_data_o),
        .app_wdf_mask_o        (app_wdf_mask_o),
        .app_wdf_wren_o        (app_wdf_wren_o),
        .app_wdf_end_o         (app_wdf_end_o),
        .app_wdf_rdy_i         (app_wdf_rdy_i),
        .app_rd_data_i         (app_rd_data_i),
        .app_rd_data_valid_i   (app_rd_data_valid_i)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Present a packet and expect it taken this cycle; consumed at the edge.
    task automatic send_pkt(input logic wr, input logic [27:0] addr, input string tag);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {wr, addr};
        settle();
        check_eq(tag, dma_pkt_yumi_o, 1'b1);
        cyc();
        dma_pkt_v_i = 1'b0;
    endtask

    // Run the four read commands, optionally stalling one burst.
    task automatic issue_rd_cmds(input logic [27:0] base, input int stall_burst,
                                 input int stall_cycles, input string tag);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_burst) begin
                app_rdy_i = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    settle();
                    check_eq({tag, "_stall_en"}, app_en_o, 1'b1);
                    check_eq({tag, "_stall_addr"}, app_addr_o, base + 28'(8 * k));
                    cyc();
                end
            end
            app_rdy_i = 1'b1;
            settle();
            check_eq({tag, "_en"}, app_en_o, 1'b1);
            check_eq({tag, "_cmd"}, app_cmd_o, 3'b001);
            check_eq({tag, "_addr"}, app_addr_o, base + 28'(8 * k));
            cyc();
        end
        app_rdy_i = 1'b0;
        settle();
        check_eq({tag, "_done_en"}, app_en_o, 1'b0);
    endtask

    // Drive four MIG returns on consecutive cycles and take the beats back,
    // holding ready_and low for the first ready_delay cycles. When a packet
    // is left pending on dma_pkt_v_i it must stay refused throughout.
    task automatic return_and_drain(input int first, input int ready_delay, input string tag);
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            app_rd_data_valid_i  = (i < 4);
            app_rd_data_i        = (i < 4) ? rd_word[first + i] : '0;
            dma_data_ready_and_i = (i >= ready_delay);
            if (i < 4) begin
                exp_q.push_back(rd_word[first + i][63:0]);
                exp_q.push_back(rd_word[first + i][127:64]);
            end
            settle();
            if (i == 0) check_eq({tag, "_v_before_return"}, dma_data_v_o, 1'b0);
            if (i == 1) check_eq({tag, "_v_latency"}, dma_data_v_o, 1'b1);
            if (dma_pkt_v_i) check_eq({tag, "_pkt_refused"}, dma_pkt_yumi_o, 1'b0);
            if (dma_data_v_o && dma_data_ready_and_i) begin
                // the latest push is not visible yet, so the queue is never empty here
                check_eq({tag, "_beat"}, dma_data_o, exp_q.pop_front());
            end
            cyc();
            if (i >= 3 && exp_q.size() == 0) done = 1;
        end
        app_rd_data_valid_i  = 1'b0;
        dma_data_ready_and_i = 1'b0;
        if (!done) begin
            check_eq({tag, "_drain_timeout"}, 1'b0, 1'b1);
            exp_q.delete();
        end
        settle();
        check_eq({tag, "_v_after_drain"}, dma_data_v_o, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rd_word[i] = {32'hA500_0000 + 32'(i * 16 + 3), 32'hA500_0000 + 32'(i * 16 + 2),
                          32'hA500_0000 + 32'(i * 16 + 1), 32'hA500_0000 + 32'(i * 16)};
            wr_beat[i] = 64'h5700_0000_0000_0000 + 64'(i) * 64'h0000_0101_0101_0101;
        end

        reset_i               = 1'b1;
        init_calib_complete_i = 1'b0;
        dma_pkt_i             = '0;
        dma_pkt_v_i           = 1'b0;
        dma_data_ready_and_i  = 1'b0;
        dma_data_i            = '0;
        dma_data_v_i          = 1'b0;
        app_rdy_i             = 1'b0;
        app_wdf_rdy_i         = 1'b0;
        app_rd_data_i         = '0;
        app_rd_data_valid_i   = 1'b0;
        cyc();
        cyc();
        settle();
        check_eq("rst_app_en",  app_en_o, 1'b0);
        check_eq("rst_app_cmd", app_cmd_o, 3'b000);
        check_eq("rst_app_addr", app_addr_o, 28'h0);
        check_eq("rst_wdf_wren", app_wdf_wren_o, 1'b0);
        check_eq("rst_data_v",  dma_data_v_o, 1'b0);
        check_eq("rst_pkt_yumi", dma_pkt_yumi_o, 1'b0);
        reset_i = 1'b0;
        cyc();

        // 1. calibration gating
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {1'b0, 28'h40};
        for (int i = 0; i < 20; i++) begin
            settle();
            check_eq("calib_gate_yumi", dma_pkt_yumi_o, 1'b0);
            cyc();
        end
        init_calib_complete_i = 1'b1;
        send_pkt(1'b0, 28'h40, "calib_release_yumi");

        // 2. read with command stall on burst 1
        issue_rd_cmds(28'h20, 1, 3, "rd0");
        return_and_drain(0, 0, "rd0");

        // 3. read with output back-pressure; next read refused until drained
        send_pkt(1'b0, 28'h100, "rd1_accept");
        issue_rd_cmds(28'h80, -1, 0, "rd1");
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {1'b0, 28'h0};
        return_and_drain(4, 10, "rd1");
        check_eq("rd2_accept_after_pop", dma_pkt_yumi_o, 1'b1);
        cyc();
        dma_pkt_v_i = 1'b0;
        issue_rd_cmds(28'h0, -1, 0, "rd2");
        return_and_drain(0, 0, "rd2");

        // 4. write with wdf stall, then 5. back-to-back read
        send_pkt(1'b1, 28'h80, "wr_accept");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                dma_data_v_i = 1'b1;
                dma_data_i   = wr_beat[2 * k + j];
                settle();
                check_eq("wr_data_yumi", dma_data_yumi_o, 1'b1);
                cyc();
            end
            dma_data_v_i = 1'b0;
            if (k == 1) begin
                for (int s = 0; s < 2; s++) begin
                    settle();
                    check_eq("wr_stall_wren", app_wdf_wren_o, 1'b1);
                    check_eq("wr_stall_data", app_wdf_data_o, {wr_beat[2 * k + 1], wr_beat[2 * k]});
                    cyc();
                end
            end
            app_wdf_rdy_i = 1'b1;
            settle();
            check_eq("wr_wdf_wren", app_wdf_wren_o, 1'b1);
            check_eq("wr_wdf_end",  app_wdf_end_o, 1'b1);
            check_eq("wr_wdf_mask", app_wdf_mask_o, 16'h0);
            check_eq("wr_wdf_data", app_wdf_data_o, {wr_beat[2 * k + 1], wr_beat[2 * k]});
            check_eq("wr_no_cmd_before_data", app_en_o, 1'b0);
            cyc();
            app_wdf_rdy_i = 1'b0;
            app_rdy_i     = 1'b1;
            if (k == 3) begin
                dma_pkt_v_i = 1'b1;
                dma_pkt_i   = {1'b0, 28'h40};
            end
            settle();
            check_eq("wr_cmd_en",   app_en_o, 1'b1);
            check_eq("wr_cmd_cmd",  app_cmd_o, 3'b000);
            check_eq("wr_cmd_addr", app_addr_o, 28'h40 + 28'(8 * k));
            check_eq("wr_cmd_wren_low", app_wdf_wren_o, 1'b0);
            if (k == 3) check_eq("b2b_rd_not_yet", dma_pkt_yumi_o, 1'b0);
            cyc();
            app_rdy_i = 1'b0;
        end
        send_pkt(1'b0, 28'h40, "b2b_rd_accept");
        issue_rd_cmds(28'h20, -1, 0, "b2b");
        return_and_drain(4, 0, "b2b");

        // 6. reset in the middle of a write
        send_pkt(1'b1, 28'h200, "rstw_accept");
        dma_data_v_i = 1'b1;
        dma_data_i   = wr_beat[0];
        cyc();
        dma_data_i   = wr_beat[1];
        cyc();
        dma_data_v_i  = 1'b0;
        app_wdf_rdy_i = 1'b1;
        cyc();
        app_wdf_rdy_i = 1'b0;
        app_rdy_i     = 1'b1;
        cyc();
        app_rdy_i    = 1'b0;
        dma_data_v_i = 1'b1;
        dma_data_i   = wr_beat[2];
        cyc();
        dma_data_i   = wr_beat[3];
        settle();
        check_eq("rstw_pre_yumi", dma_data_yumi_o, 1'b1);
        check_eq("rstw_pre_addr", app_addr_o, 28'h108);
        #1;
        reset_i = 1'b1;
        #1;
        check_eq("rstw_async_yumi", dma_data_yumi_o, 1'b0);
        check_eq("rstw_async_addr", app_addr_o, 28'h0);
        check_eq("rstw_async_en", app_en_o, 1'b0);
        cyc();
        dma_data_v_i = 1'b0;
        reset_i      = 1'b0;
        cyc();
        send_pkt(1'b0, 28'h40, "rstw_rd_accept");
        issue_rd_cmds(28'h20, -1, 0, "rstw_rd");
        return_and_drain(0, 0, "rstw_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_mig_dma_app_adapter
`default_nettype wire
